// File: rtl/single_wire_master.sv
// Half-duplex single-wire transaction master: strobe, 8-bit MSB-first transmit,
// bus turnaround, 8-bit receive, then a one-cycle result pulse with collision flag.
module single_wire_master #(
    parameter int unsigned TURNAROUND = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic [7:0] i_tx_byte,
    output logic       o_ready,
    output logic       o_stb,
    inout  wire        io_data,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STB,
        S_TX,
        S_TA,
        S_RX,
        S_DONE
    } state_t;

    localparam logic [3:0] TA_LAST = 4'(TURNAROUND - 1);

    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic [7:0] tx_shift_reg;
    logic [6:0] rx_shift_reg;
    logic       oe_reg;
    logic       col_reg;
    logic       stb_reg;
    logic       valid_reg;
    logic [7:0] rx_byte_reg;
    logic       err_reg;

    // The line is only ever driven during TX; the bit on the wire is always tx_shift_reg[7].
    assign io_data = oe_reg ? tx_shift_reg[7] : 1'bz;

    // Gated with the reset input so the master never advertises readiness while held in reset.
    assign o_ready    = (state_reg == S_IDLE) && i_rst_n;
    assign o_stb      = stb_reg;
    assign o_rx_valid = valid_reg;
    assign o_rx_byte  = rx_byte_reg;
    assign o_err      = err_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 4'd0;
            tx_shift_reg <= 8'h00;
            rx_shift_reg <= 7'h00;
            oe_reg       <= 1'b0;
            col_reg      <= 1'b0;
            stb_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            rx_byte_reg  <= 8'h00;
            err_reg      <= 1'b0;
        end else begin
            stb_reg   <= 1'b0;
            valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_req) begin
                        tx_shift_reg <= i_tx_byte;
                        col_reg      <= 1'b0;
                        stb_reg      <= 1'b1;
                        state_reg    <= S_STB;
                    end
                end
                S_STB: begin
                    oe_reg    <= 1'b1;
                    cnt_reg   <= 4'd0;
                    state_reg <= S_TX;
                end
                S_TX: begin
                    // Anything other than our own bit on the wire means another driver fought us.
                    if (io_data != tx_shift_reg[7]) begin
                        col_reg <= 1'b1;
                    end
                    tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                    if (cnt_reg == 4'd7) begin
                        oe_reg    <= 1'b0;
                        cnt_reg   <= 4'd0;
                        state_reg <= S_TA;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                S_TA: begin
                    if (cnt_reg == TA_LAST) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= S_RX;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                S_RX: begin
                    rx_shift_reg <= {rx_shift_reg[5:0], io_data};
                    if (cnt_reg == 4'd7) begin
                        rx_byte_reg <= {rx_shift_reg, io_data};
                        err_reg     <= col_reg;
                        valid_reg   <= 1'b1;
                        cnt_reg     <= 4'd0;
                        state_reg   <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    oe_reg    <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_single_wire_master.sv
// Directed bench for single_wire_master: loopback device model on a pulled-up line,
// collision injection, ignored requests, mid-transfer reset and a TURNAROUND=5 instance.
module tb_single_wire_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       req2 = 1'b0;
    logic [7:0] tx_byte = 8'h00;

    logic       ready, stb, rx_valid, err;
    logic [7:0] rx_byte;
    logic       ready2, stb2, rx_valid2, err2;
    logic [7:0] rx_byte2;

    wire        bus;
    wire        bus2;

    logic       dev_en = 1'b0;
    logic       dev_val = 1'b0;
    logic       dev_armed = 1'b0;
    logic [7:0] dev_resp = 8'h00;
    logic [7:0] dev_shift;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    pullup (bus);
    pullup (bus2);
    assign bus = dev_en ? dev_val : 1'bz;

    single_wire_master #(.TURNAROUND(2)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_tx_byte  (tx_byte),
        .o_ready    (ready),
        .o_stb      (stb),
        .io_data    (bus),
        .o_rx_valid (rx_valid),
        .o_rx_byte  (rx_byte),
        .o_err      (err)
    );

    single_wire_master #(.TURNAROUND(5)) dut_ta5 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req2),
        .i_tx_byte  (tx_byte),
        .o_ready    (ready2),
        .o_stb      (stb2),
        .io_data    (bus2),
        .o_rx_valid (rx_valid2),
        .o_rx_byte  (rx_byte2),
        .o_err      (err2)
    );

    // Device model: after seeing the strobe, waits out TX and a 2-cycle turnaround, then returns dev_resp MSB first.
    always begin
        @(negedge clk);
        if (dev_armed && stb === 1'b1) begin
            dev_shift = dev_resp;
            repeat (11) @(posedge clk);
            for (int i = 7; i >= 0; i--) begin
                #1;
                dev_en  = 1'b1;
                dev_val = dev_shift[i];
                @(posedge clk);
            end
            #1;
            dev_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_valid === 1'b1) valid_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] b);
        req     = 1'b1;
        tx_byte = b;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_valid(inout int k);
        while (rx_valid !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", stb); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte: got %h expected 00", rx_byte); end
        checks++; if (bus !== 1'b1) begin errors++; $display("FAIL reset_line: got %b expected 1 (released)", bus); end
        rst_n = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", ready); end
        tick();
        $display("reset: ready=%b rx_byte=%h", ready, rx_byte);
    endtask

    task automatic test_echo();
        logic [7:0] exp;
        int k;
        exp       = 8'h81;
        dev_resp  = 8'h81;
        dev_armed = 1'b1;
        accept(8'h81);
        k = 0;
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL echo_stb: got %b expected 1", stb); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL echo_ready_busy: got %b expected 0", ready); end
        for (int i = 7; i >= 0; i--) begin
            tick();
            k++;
            if (i == 7) begin
                checks++; if (stb !== 1'b0) begin errors++; $display("FAIL echo_stb_width: got %b expected 0", stb); end
            end
            checks++; if (bus !== exp[i]) begin errors++; $display("FAIL echo_tx_bit%0d: got %b expected %b", i, bus, exp[i]); end
        end
        wait_valid(k);
        checks++; if (k != 19) begin errors++; $display("FAIL echo_latency: got %0d expected 19", k); end
        checks++; if (rx_byte !== 8'h81) begin errors++; $display("FAIL echo_rx_byte: got %h expected 81", rx_byte); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL echo_err: got %b expected 0", err); end
        tick();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL echo_valid_width: got %b expected 0", rx_valid); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL echo_ready_after: got %b expected 1", ready); end
        checks++; if (rx_byte !== 8'h81) begin errors++; $display("FAIL echo_rx_hold: got %h expected 81", rx_byte); end
        $display("echo: tx=81 rx=%h err=%b latency=%0d", rx_byte, err, k);
    endtask

    task automatic test_distinct();
        int k;
        dev_resp = 8'h3C;
        accept(8'hA5);
        k = 0;
        repeat (8) begin tick(); k++; end
        for (int t = 0; t < 2; t++) begin
            tick();
            k++;
            checks++; if (bus !== 1'b1) begin errors++; $display("FAIL distinct_ta_line%0d: got %b expected 1 (released)", t, bus); end
        end
        wait_valid(k);
        checks++; if (k != 19) begin errors++; $display("FAIL distinct_latency: got %0d expected 19", k); end
        checks++; if (rx_byte !== 8'h3C) begin errors++; $display("FAIL distinct_rx_byte: got %h expected 3c", rx_byte); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL distinct_err: got %b expected 0", err); end
        tick();
        $display("distinct: tx=a5 rx=%h err=%b latency=%0d", rx_byte, err, k);
    endtask

    task automatic test_collision();
        int k;
        dev_resp = 8'h5A;
        accept(8'h80);
        k = 0;
        tick();
        k++;
        force bus = 1'b0;
        tick();
        k++;
        release bus;
        wait_valid(k);
        checks++; if (k != 19) begin errors++; $display("FAIL collision_latency: got %0d expected 19", k); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL collision_err: got %b expected 1", err); end
        checks++; if (rx_byte !== 8'h5A) begin errors++; $display("FAIL collision_rx_byte: got %h expected 5a", rx_byte); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL collision_err_hold: got %b expected 1", err); end
        $display("collision: tx=80 rx=%h err=%b latency=%0d", rx_byte, err, k);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        int k;
        dev_resp = 8'h96;
        accept(8'h3C);
        k = 0;
        while (k < 13) begin tick(); k++; end
        req     = 1'b1;
        tx_byte = 8'hFF;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ignored_ready: got %b expected 0", ready); end
        tick();
        k++;
        req = 1'b0;
        wait_valid(k);
        checks++; if (k != 19) begin errors++; $display("FAIL ignored_latency: got %0d expected 19", k); end
        checks++; if (rx_byte !== 8'h96) begin errors++; $display("FAIL ignored_rx_byte: got %h expected 96", rx_byte); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ignored_err_cleared: got %b expected 0", err); end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", ready); end
        $display("ignored_req: tx=3c rx=%h err=%b latency=%0d", rx_byte, err, k);

        exp      = 8'h42;
        dev_resp = 8'h24;
        accept(8'h42);
        tx_byte = 8'hFF;
        k = 0;
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL b2b_stb: got %b expected 1", stb); end
        for (int i = 7; i >= 0; i--) begin
            tick();
            k++;
            checks++; if (bus !== exp[i]) begin errors++; $display("FAIL b2b_tx_bit%0d: got %b expected %b", i, bus, exp[i]); end
        end
        wait_valid(k);
        checks++; if (k != 19) begin errors++; $display("FAIL b2b_latency: got %0d expected 19", k); end
        checks++; if (rx_byte !== 8'h24) begin errors++; $display("FAIL b2b_rx_byte: got %h expected 24", rx_byte); end
        tick();
        $display("back_to_back: tx=42 rx=%h err=%b latency=%0d", rx_byte, err, k);
    endtask

    task automatic test_reset_mid_tx();
        int k;
        dev_armed = 1'b0;
        accept(8'h81);
        repeat (5) tick();
        checks++; if (bus !== 1'b0) begin errors++; $display("FAIL midrst_bit3: got %b expected 0", bus); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus !== 1'b1) begin errors++; $display("FAIL midrst_line: got %b expected 1 (released)", bus); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", ready); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL midrst_rx_byte: got %h expected 00", rx_byte); end
        tick();
        tick();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", rx_valid); end
        dev_armed = 1'b1;
        dev_resp  = 8'hC3;
        req       = 1'b1;
        tx_byte   = 8'h81;
        rst_n     = 1'b1;
        tick();
        req = 1'b0;
        k = 0;
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL midrst_first_accept: got %b expected 1", stb); end
        wait_valid(k);
        checks++; if (k != 19) begin errors++; $display("FAIL midrst_latency: got %0d expected 19", k); end
        checks++; if (rx_byte !== 8'hC3) begin errors++; $display("FAIL midrst_rx_byte_after: got %h expected c3", rx_byte); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", err); end
        tick();
        $display("reset_mid_tx: tx=81 rx=%h err=%b latency=%0d", rx_byte, err, k);
    endtask

    task automatic test_turnaround5();
        int k;
        req2    = 1'b1;
        tx_byte = 8'h5A;
        tick();
        req2 = 1'b0;
        k = 0;
        checks++; if (stb2 !== 1'b1) begin errors++; $display("FAIL ta5_stb: got %b expected 1", stb2); end
        while (rx_valid2 !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        checks++; if (k != 22) begin errors++; $display("FAIL ta5_latency: got %0d expected 22", k); end
        checks++; if (rx_byte2 !== 8'hFF) begin errors++; $display("FAIL ta5_rx_byte: got %h expected ff", rx_byte2); end
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL ta5_err: got %b expected 0", err2); end
        tick();
        $display("turnaround5: tx=5a rx=%h err=%b latency=%0d", rx_byte2, err2, k);
    endtask

    task automatic test_valid_count();
        checks++; if (valid_cnt != 6) begin errors++; $display("FAIL valid_pulse_count: got %0d expected 6", valid_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_echo();
        test_distinct();
        test_collision();
        test_back_to_back();
        test_reset_mid_tx();
        test_turnaround5();
        test_valid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
